// File: rtl/cpu_defs.sv
// Shared CPU definitions: word width, UART register addresses and the
// Ram1 controller state encoding.
package cpu_defs;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [WORD_W-1:0] UART_STAT_ADDR = 16'hBF01;

    // Ram1 controller states.
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SR_RD   = 4'd1;
    localparam logic [3:0] SR_WR1  = 4'd2;
    localparam logic [3:0] SR_WR2  = 4'd3;
    localparam logic [3:0] UA_RD1  = 4'd4;
    localparam logic [3:0] UA_RD2  = 4'd5;
    localparam logic [3:0] UA_WR1  = 4'd6;
    localparam logic [3:0] UA_WR2  = 4'd7;
    localparam logic [3:0] UA_WAIT = 4'd8;
    localparam logic [3:0] DONE    = 4'd9;

endpackage

// File: rtl/ram1_bus_drv.sv
// Tristate driver for the shared Ram1 data bus. The controller only
// decides when to drive; the inout handling lives here.
module ram1_bus_drv
    import cpu_defs::*;
(
    input  logic              drive_en,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    inout  wire  [WORD_W-1:0] bus
);

    assign bus   = drive_en ? wdata : {WORD_W{1'bz}};
    assign rdata = bus;

endmodule

// File: rtl/ram1_uart_ctrl.sv
// MEM-stage responder: runs one load/store at a time on the shared Ram1
// bus as either an external SRAM cycle or a UART cycle, and returns the
// result with a one-cycle done pulse.
module ram1_uart_ctrl
    import cpu_defs::*;
#(
    parameter logic [WORD_W-1:0] UART_DATA_ADDR = cpu_defs::UART_DATA_ADDR,
    parameter logic [WORD_W-1:0] UART_STAT_ADDR = cpu_defs::UART_STAT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              done,
    output logic              busy,
    output logic [17:0]       Ram1Addr,
    inout  wire  [WORD_W-1:0] Ram1Data,
    output logic              Ram1OE,
    output logic              Ram1WE,
    output logic              Ram1EN,
    output logic              wrn,
    output logic              rdn,
    input  logic              data_ready,
    input  logic              tbre,
    input  logic              tsre
);

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] resp_q;
    logic              we_q;
    logic              sram_q;     // access in flight targets the SRAM
    logic              bus_drive;
    logic [WORD_W-1:0] bus_in;

    logic accept;
    logic hit_data;
    logic hit_stat;

    assign accept   = (state == IDLE) && req_valid;
    assign hit_data = (req_addr == UART_DATA_ADDR);
    assign hit_stat = (req_addr == UART_STAT_ADDR);

    // Next-state selection: decode the path at acceptance, then walk the
    // fixed strobe sequence; only UA_WAIT waits on the UART.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (hit_data)      state_nxt = req_we ? UA_WR1 : UA_RD1;
                    else if (hit_stat) state_nxt = DONE;
                    else               state_nxt = req_we ? SR_WR1 : SR_RD;
                end
            end
            SR_RD:   state_nxt = DONE;
            SR_WR1:  state_nxt = SR_WR2;
            SR_WR2:  state_nxt = DONE;
            UA_RD1:  state_nxt = UA_RD2;
            UA_RD2:  state_nxt = DONE;
            UA_WR1:  state_nxt = UA_WR2;
            UA_WR2:  state_nxt = UA_WAIT;
            UA_WAIT: if (tbre && tsre) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus request latches; the reset aborts any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sram_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                we_q    <= req_we;
                sram_q  <= !hit_data && !hit_stat;
            end
        end
    end

    // Load result: status is sampled at acceptance, bus reads at the end of
    // the last strobe cycle; stores leave the previous result untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_q <= '0;
        end else if (accept && hit_stat && !req_we) begin
            resp_q <= {14'b0, data_ready, tbre & tsre};
        end else if (state == SR_RD) begin
            resp_q <= bus_in;
        end else if (state == UA_RD2) begin
            resp_q <= {8'b0, bus_in[7:0]};
        end
    end

    // Bus strobes decoded from the state. The chip stays selected through an
    // SRAM DONE cycle, and a store keeps driving data there for hold time.
    always_comb begin
        Ram1EN    = 1'b1;
        Ram1OE    = 1'b1;
        Ram1WE    = 1'b1;
        rdn       = 1'b1;
        wrn       = 1'b1;
        bus_drive = 1'b0;
        case (state)
            SR_RD: begin
                Ram1EN = 1'b0;
                Ram1OE = 1'b0;
            end
            SR_WR1: begin
                Ram1EN    = 1'b0;
                bus_drive = 1'b1;
            end
            SR_WR2: begin
                Ram1EN    = 1'b0;
                Ram1WE    = 1'b0;
                bus_drive = 1'b1;
            end
            UA_RD1, UA_RD2: rdn = 1'b0;
            UA_WR1: bus_drive = 1'b1;
            UA_WR2: begin
                wrn       = 1'b0;
                bus_drive = 1'b1;
            end
            DONE: begin
                Ram1EN    = !sram_q;
                bus_drive = sram_q && we_q;
            end
            default: ;
        endcase
    end

    ram1_bus_drv u_bus_drv (
        .drive_en (bus_drive),
        .wdata    (wdata_q),
        .rdata    (bus_in),
        .bus      (Ram1Data)
    );

    assign Ram1Addr   = {2'b00, addr_q};
    assign resp_rdata = resp_q;
    assign done       = (state == DONE);
    assign busy       = req_valid && !done;

endmodule
